// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Byte FIFO that feeds a UART transmitter through a start/done handshake.
//   The host pushes bytes with wr_en/wr_data. The sender FSM presents the
//   oldest byte on tx_data and raises tx_start. It pops that byte only when
//   the transmitter reports completion with a rising edge on tx_done. Until
//   then the byte stays in the FIFO and is included in count.
//
//   Optional feature, macro UART_TX_FIFO_RETRY_EN:
//     A completion reported with tx_err=1 resends the byte instead of
//     popping it. At most 3 retries are made per byte. The following
//     completion pops the byte whatever tx_err says.
//     Without the macro, every completion pops and tx_err is ignored.
//
// Ports
//   clk      in   single clock, rising edge
//   rst      in   asynchronous active-low reset
//   wr_en    in   host write strobe (one byte per cycle)
//   wr_data  in   host byte
//   flush    in   synchronous clear of FIFO and sender (wins over wr_en)
//   full     out  count == DEPTH
//   empty    out  count == 0
//   count    out  stored bytes, including the byte being sent
//   ovf_err  out  sticky: write attempted while full
//   tx_start out  request to transmitter (level, high only while sending)
//   tx_data  out  byte presented to transmitter
//   tx_done  in   transmitter completion (level, synchronous to clk)
//   tx_err   in   transmitter error, sampled with the tx_done rise
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          flush,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          ovf_err,
  output logic          tx_start,
  output logic [7:0]    tx_data,
  input  logic          tx_done,
  input  logic          tx_err
);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT_LOW} state_t;

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [7:0]    mem [DEPTH];
  state_t        state_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [AW:0]   count_reg;
  logic          ovf_reg;
  logic          tx_start_reg;
  logic [7:0]    tx_data_reg;
  logic          tx_done_q;

  logic done_rise;
  logic send_done;
  logic push;
  logic pop;

  assign full     = (count_reg == FULL_CNT);
  assign empty    = (count_reg == '0);
  assign count    = count_reg;
  assign ovf_err  = ovf_reg;
  assign tx_start = tx_start_reg;
  assign tx_data  = tx_data_reg;

  // Completion is an edge of the tx_done level. Only an edge seen while
  // sending has any effect.
  assign done_rise = tx_done & ~tx_done_q;
  assign send_done = (state_reg == SEND) & done_rise;

  // The full test uses the current count, so a write into a full FIFO is
  // dropped even when a pop frees a slot in the same cycle.
  assign push = wr_en & ~full & ~flush;

`ifdef UART_TX_FIFO_RETRY_EN
  logic [1:0] retry_cnt_reg;
  // Pop on success, or once three retries have been used up.
  assign pop = send_done & (~tx_err | (retry_cnt_reg == 2'd3));
`else
  assign pop = send_done;
  // tx_err has no effect when retries are not built in.
  logic unused_tx_err;
  assign unused_tx_err = tx_err;
`endif

  // Storage array has no reset, so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      count_reg     <= '0;
      ovf_reg       <= 1'b0;
      tx_start_reg  <= 1'b0;
      tx_data_reg   <= 8'h00;
      tx_done_q     <= 1'b0;
`ifdef UART_TX_FIFO_RETRY_EN
      retry_cnt_reg <= 2'd0;
`endif
    end else begin
      tx_done_q <= tx_done;
      if (flush) begin
        state_reg     <= IDLE;
        rd_ptr_reg    <= '0;
        wr_ptr_reg    <= '0;
        count_reg     <= '0;
        ovf_reg       <= 1'b0;
        tx_start_reg  <= 1'b0;
`ifdef UART_TX_FIFO_RETRY_EN
        retry_cnt_reg <= 2'd0;
`endif
      end else begin
        if (wr_en && full) begin
          ovf_reg <= 1'b1;
        end
        if (push) begin
          wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
        end
        if (pop) begin
          rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
        end
        if (push && !pop) begin
          count_reg <= count_reg + CNT_ONE;
        end else if (pop && !push) begin
          count_reg <= count_reg - CNT_ONE;
        end

        case (state_reg)
          IDLE: begin
            if (!empty) begin
              state_reg <= LOAD;
            end
          end
          LOAD: begin
            // Registered read of the head byte. This is the only place
            // where tx_data changes.
            tx_data_reg  <= mem[rd_ptr_reg];
            tx_start_reg <= 1'b1;
            state_reg    <= SEND;
          end
          SEND: begin
            if (done_rise) begin
              tx_start_reg <= 1'b0;
              state_reg    <= WAIT_LOW;
`ifdef UART_TX_FIFO_RETRY_EN
              if (pop) begin
                retry_cnt_reg <= 2'd0;
              end else begin
                retry_cnt_reg <= retry_cnt_reg + 2'd1;
              end
`endif
            end
          end
          WAIT_LOW: begin
            if (!tx_done) begin
              state_reg <= IDLE;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule
